// File: rtl/vga_sprite_engine.sv
// VGA timing generator with an N-sprite 1bpp compositor. Sprite attributes are committed at vblank start,
// and per-frame collision flags are reported. rgb/hsync/vsync are registered together on the pixel enable.
module vga_sprite_engine #(
    parameter int H_DISP   = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_DISP   = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CLK_DIV  = 2,
    parameter bit SYNC_POL = 1'b0,
    parameter int NUM_SPR  = 4,
    parameter int SPR_SZ   = 16,
    localparam int IW = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1,
    localparam int RW = (SPR_SZ > 1) ? $clog2(SPR_SZ) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 spr_we,
    input  logic [IW-1:0]        spr_idx,
    input  logic [9:0]           spr_x,
    input  logic [9:0]           spr_y,
    input  logic                 spr_en,
    input  logic [2:0]           spr_color,
    input  logic                 bmp_we,
    input  logic [IW-1:0]        bmp_idx,
    input  logic [RW-1:0]        bmp_row,
    input  logic [SPR_SZ-1:0]    bmp_data,
    input  logic [2:0]           bg_color,
    output logic                 hsync,
    output logic                 vsync,
    output logic [2:0]           rgb,
    output logic                 frame_tick,
    output logic [NUM_SPR-1:0]   collision
);
    localparam int H_TOT = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_DISP + V_FP + V_SYNC + V_BP;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       en;
        logic [2:0] color;
    } spr_t;

    logic                       pe;
    logic [HW-1:0]              h_reg;
    logic [VW-1:0]              v_reg;
    logic                       h_last, v_last, commit, visible, hs_act, vs_act;
    logic [10:0]                h_ext, v_ext;
    logic [NUM_SPR-1:0]         hit, acc_reg;
    logic [NUM_SPR-1:0][2:0]    spr_colors;
    logic [2:0]                 pix_color;
    logic                       multi_hit;
    spr_t                       new_spr;

    generate
        if (CLK_DIV <= 1) begin : g_nodiv
            assign pe = 1'b1;
        end else begin : g_div
            localparam int DW = $clog2(CLK_DIV);
            logic [DW-1:0] div_reg;
            assign pe = (div_reg == DW'(CLK_DIV - 1));
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)  div_reg <= '0;
                else if (pe) div_reg <= '0;
                else         div_reg <= div_reg + 1'b1;
            end
        end
    endgenerate

    assign h_last  = (h_reg == HW'(H_TOT - 1));
    assign v_last  = (v_reg == VW'(V_TOT - 1));
    // Commit lands on the pe that moves (h,v) onto (0,V_DISP).
    assign commit  = pe && h_last && (v_reg == VW'(V_DISP - 1));
    assign visible = (h_reg < HW'(H_DISP)) && (v_reg < VW'(V_DISP));
    assign hs_act  = (h_reg >= HW'(H_DISP + H_FP)) && (h_reg < HW'(H_DISP + H_FP + H_SYNC));
    assign vs_act  = (v_reg >= VW'(V_DISP + V_FP)) && (v_reg < VW'(V_DISP + V_FP + V_SYNC));
    assign h_ext   = 11'(h_reg);
    assign v_ext   = 11'(v_reg);
    assign new_spr = {spr_x, spr_y, spr_en, spr_color};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_reg <= '0;
            v_reg <= '0;
        end else if (pe) begin
            h_reg <= h_last ? '0 : h_reg + 1'b1;
            if (h_last) v_reg <= v_last ? '0 : v_reg + 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SPR; gi++) begin : g_spr
            spr_t              shadow_reg, active_reg;
            logic [SPR_SZ-1:0] bmp_mem [SPR_SZ];
            logic [SPR_SZ-1:0] row_bits;
            logic [10:0]       x_beg, y_beg, x_end, y_end;
            logic [RW-1:0]     row_sel, col_sel;
            logic              in_box;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    shadow_reg <= '0;
                    active_reg <= '0;
                end else begin
                    if (commit) active_reg <= shadow_reg;
                    if (spr_we && spr_idx == IW'(gi)) shadow_reg <= new_spr;
                end
            end

            always_ff @(posedge clk) begin
                if (bmp_we && bmp_idx == IW'(gi)) bmp_mem[bmp_row] <= bmp_data;
            end

            // 11-bit bounds so a sprite hanging off the right/bottom clips instead of wrapping to 0.
            assign x_beg    = {1'b0, active_reg.x};
            assign y_beg    = {1'b0, active_reg.y};
            assign x_end    = x_beg + 11'(SPR_SZ);
            assign y_end    = y_beg + 11'(SPR_SZ);
            assign in_box   = active_reg.en && (h_ext >= x_beg) && (h_ext < x_end)
                              && (v_ext >= y_beg) && (v_ext < y_end);
            assign row_sel  = RW'(v_ext - y_beg);
            assign col_sel  = RW'(h_ext - x_beg);
            assign row_bits = bmp_mem[row_sel];
            assign hit[gi]  = in_box && row_bits[col_sel];
            assign spr_colors[gi] = active_reg.color;
        end
    endgenerate

    always_comb begin
        pix_color = bg_color;
        for (int i = NUM_SPR - 1; i >= 0; i--) begin
            if (hit[i]) pix_color = spr_colors[i];
        end
        if (!visible) pix_color = 3'b000;
    end

    assign multi_hit = |(hit & (hit - 1'b1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb        <= 3'b000;
            hsync      <= ~SYNC_POL;
            vsync      <= ~SYNC_POL;
            frame_tick <= 1'b0;
            collision  <= '0;
            acc_reg    <= '0;
        end else begin
            frame_tick <= commit;
            if (pe) begin
                rgb   <= pix_color;
                hsync <= hs_act ? SYNC_POL : ~SYNC_POL;
                vsync <= vs_act ? SYNC_POL : ~SYNC_POL;
            end
            if (commit) begin
                collision <= acc_reg;
                acc_reg   <= '0;
            end else if (pe && visible && multi_hit) begin
                acc_reg <= acc_reg | hit;
            end
        end
    end
endmodule
